// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame sequencer.
// Holds the frame FSM state enum, the default sync marker and command codes.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DHI,
        DLO,
        CHK
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [7:0] CMD_PADDLE = 8'h01;
    localparam logic [7:0] CMD_SCORE  = 8'h02;
    localparam logic [7:0] CMD_START  = 8'h03;

    localparam int FRAME_LEN = 5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Generic saturating timeout counter, used for byte timeout and link watchdog.
// Ports: clk, rst (async high), clear, enable -> expired (count == LIMIT-1).
module timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // Clear has priority; the count parks at LAST until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles UART bytes into SYNC/CMD/D_HI/D_LO/CHK frames with xor checksum,
// inter-byte timeout, link watchdog and saturating error counter.
// Ports: clk, rst, rx_byte/rx_valid in; frame_valid, frame_cmd, frame_data,
// chk_err, timeout_err, err_count, link_up, busy out (all registered).
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         BYTE_TIMEOUT = 135_417,
    parameter int         LINK_TIMEOUT = 6_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        frame_valid,
    output logic [7:0]  frame_cmd,
    output logic [15:0] frame_data,
    output logic        chk_err,
    output logic        timeout_err,
    output logic [7:0]  err_count,
    output logic        link_up,
    output logic        busy
);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cmd_q;
    logic [7:0] hi_q;
    logic [7:0] lo_q;
    logic [7:0] acc_q;

    logic good;
    logic bad;
    logic tmo;
    logic byte_exp;
    logic link_exp;

    // Held cleared while idle, so it starts from zero on entry to CMD.
    timeout_counter #(
        .LIMIT (BYTE_TIMEOUT)
    ) u_byte_to (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid || state_q == IDLE),
        .enable  (state_q != IDLE),
        .expired (byte_exp)
    );

    timeout_counter #(
        .LIMIT (LINK_TIMEOUT)
    ) u_link_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (good),
        .enable  (1'b1),
        .expired (link_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte arriving in the expiry cycle takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        good    = 1'b0;
        bad     = 1'b0;
        tmo     = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = CMD;
                    end
                end
                CMD: state_d = DHI;
                DHI: state_d = DLO;
                DLO: state_d = CHK;
                CHK: begin
                    state_d = IDLE;
                    if (rx_byte == acc_q) begin
                        good = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && byte_exp) begin
            state_d = IDLE;
            tmo     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            acc_q <= '0;
        end else if (rx_valid) begin
            unique case (state_q)
                CMD: begin
                    cmd_q <= rx_byte;
                    acc_q <= rx_byte;
                end
                DHI: begin
                    hi_q  <= rx_byte;
                    acc_q <= acc_q ^ rx_byte;
                end
                DLO: begin
                    lo_q  <= rx_byte;
                    acc_q <= acc_q ^ rx_byte;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_cmd   <= '0;
            frame_data  <= '0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= '0;
            link_up     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= good;
            chk_err     <= bad;
            timeout_err <= tmo;
            busy        <= (state_d != IDLE);
            if (good) begin
                frame_cmd  <= cmd_q;
                frame_data <= {hi_q, lo_q};
            end
            if ((bad || tmo) && err_count != 8'hFF) begin
                err_count <= err_count + 1'b1;
            end
            if (good) begin
                link_up <= 1'b1;
            end else if (link_exp) begin
                link_up <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl with short timeouts (16 / 64).
// Queue-based frame model compared every cycle plus directed literal checks.
module tb_uart_frame_ctrl;
    import uart_frame_pkg::*;

    localparam int BT = 16;
    localparam int LT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        frame_valid;
    logic [7:0]  frame_cmd;
    logic [15:0] frame_data;
    logic        chk_err;
    logic        timeout_err;
    logic [7:0]  err_count;
    logic        link_up;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_frame_ctrl #(
        .BYTE_TIMEOUT (BT),
        .LINK_TIMEOUT (LT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_data  (frame_data),
        .chk_err     (chk_err),
        .timeout_err (timeout_err),
        .err_count   (err_count),
        .link_up     (link_up),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bytes collected in a queue, frame judged when full.
    logic [7:0]  q[$];
    int          gap = 0;
    int          cyc = 0;
    int          last_fv = -1;
    logic        e_fv = 0;
    logic        e_chk = 0;
    logic        e_tmo = 0;
    logic [7:0]  e_cmd = 0;
    logic [15:0] e_data = 0;
    int          e_err = 0;
    logic        e_link = 0;
    logic        e_busy = 0;

    always @(posedge clk) begin
        logic [7:0] x;
        cyc++;
        if (rst) begin
            q.delete();
            gap = 0;
            last_fv = -1;
            e_fv = 0; e_chk = 0; e_tmo = 0;
            e_cmd = 0; e_data = 0; e_err = 0;
            e_link = 0; e_busy = 0;
        end else begin
            e_fv = 0; e_chk = 0; e_tmo = 0;
            if (rx_valid) begin
                gap = 0;
                if (q.size() > 0 || rx_byte == SYNC_BYTE_DEF) q.push_back(rx_byte);
                if (q.size() == FRAME_LEN) begin
                    x = q[1] ^ q[2] ^ q[3];
                    if (q[4] == x) begin
                        e_fv = 1;
                        e_cmd = q[1];
                        e_data = {q[2], q[3]};
                    end else begin
                        e_chk = 1;
                    end
                    q.delete();
                end
            end else if (q.size() > 0) begin
                gap++;
                if (gap == BT) begin
                    e_tmo = 1;
                    q.delete();
                end
            end
            if ((e_chk || e_tmo) && e_err < 255) e_err++;
            if (e_fv) begin
                last_fv = cyc + 1;
                e_link = 1;
            end else begin
                e_link = (last_fv >= 0) && (cyc + 1 - last_fv <= LT - 1);
            end
            e_busy = (q.size() > 0);
        end
    end

    int fv_seen = 0;
    int chk_seen = 0;
    int tmo_seen = 0;

    always @(negedge clk) begin
        if (frame_valid) fv_seen++;
        if (chk_err) chk_seen++;
        if (timeout_err) tmo_seen++;
        if (!rst) begin
            cmp("frame_valid", 32'(frame_valid), 32'(e_fv));
            cmp("chk_err", 32'(chk_err), 32'(e_chk));
            cmp("timeout_err", 32'(timeout_err), 32'(e_tmo));
            cmp("frame_cmd", 32'(frame_cmd), 32'(e_cmd));
            cmp("frame_data", 32'(frame_data), 32'(e_data));
            cmp("err_count", 32'(err_count), 32'(e_err));
            cmp("link_up", 32'(link_up), 32'(e_link));
            cmp("busy", 32'(busy), 32'(e_busy));
        end
    end

    task automatic send(input logic [7:0] b, input int spacing);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (spacing - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] k,
                              input int spacing);
        send(SYNC_BYTE_DEF, spacing);
        send(c, spacing);
        send(h, spacing);
        send(l, spacing);
        send(k, spacing);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_fv"}, 32'(frame_valid), 0);
        cmp({tag, "_cmd"}, 32'(frame_cmd), 0);
        cmp({tag, "_data"}, 32'(frame_data), 0);
        cmp({tag, "_chk"}, 32'(chk_err), 0);
        cmp({tag, "_tmo"}, 32'(timeout_err), 0);
        cmp({tag, "_err"}, 32'(err_count), 0);
        cmp({tag, "_link"}, 32'(link_up), 0);
        cmp({tag, "_busy"}, 32'(busy), 0);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        send_frame(CMD_PADDLE, 8'h12, 8'h34, 8'h27, 5);
        idle(2);
        cmp("f1_count", 32'(fv_seen), 1);
        cmp("f1_cmd", 32'(frame_cmd), 32'h01);
        cmp("f1_data", 32'(frame_data), 32'h1234);
        cmp("f1_link", 32'(link_up), 1);
        cmp("f1_err", 32'(err_count), 0);

        send_frame(8'h01, 8'h12, 8'h34, 8'h00, 2);
        idle(2);
        cmp("bad_chk", 32'(chk_seen), 1);
        cmp("bad_err", 32'(err_count), 1);
        cmp("bad_data", 32'(frame_data), 32'h1234);
        cmp("bad_busy", 32'(busy), 0);

        send(8'h00, 2);
        send(8'hFF, 2);
        send_frame(CMD_SCORE, 8'hA5, 8'h00, 8'hA7, 2);
        idle(2);
        cmp("sync_in_data_fv", 32'(fv_seen), 2);
        cmp("sync_in_data_cmd", 32'(frame_cmd), 32'h02);
        cmp("sync_in_data_data", 32'(frame_data), 32'hA500);
        cmp("sync_in_data_err", 32'(err_count), 1);

        send(SYNC_BYTE_DEF, 1);
        send(8'h01, 1);
        idle(BT - 1);
        cmp("tmo_early", 32'(tmo_seen), 0);
        idle(5);
        cmp("tmo_seen", 32'(tmo_seen), 1);
        cmp("tmo_busy", 32'(busy), 0);
        cmp("tmo_err", 32'(err_count), 2);
        send_frame(CMD_START, 8'h00, 8'h07, 8'h04, 1);
        idle(2);
        cmp("after_tmo_fv", 32'(fv_seen), 3);
        cmp("after_tmo_cmd", 32'(frame_cmd), 32'h03);

        idle(LT + 6);
        cmp("link_drop", 32'(link_up), 0);
        send_frame(8'h01, 8'h00, 8'h40, 8'h41, 1);
        idle(2);
        cmp("link_back", 32'(link_up), 1);

        for (int i = 0; i < 300; i++) send_frame(8'h01, 8'h12, 8'h34, 8'h00, 1);
        idle(2);
        cmp("err_sat", 32'(err_count), 255);

        send(SYNC_BYTE_DEF, 1);
        send(8'h01, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        idle(2);
        @(negedge clk);
        #2 rst = 1'b0;
        base = fv_seen;
        send_frame(CMD_SCORE, 8'h00, 8'h05, 8'h07, 2);
        idle(2);
        cmp("post_rst_fv", 32'(fv_seen - base), 1);
        cmp("post_rst_cmd", 32'(frame_cmd), 32'h02);
        cmp("post_rst_data", 32'(frame_data), 32'h0005);
        cmp("post_rst_link", 32'(link_up), 1);
        cmp("post_rst_err", 32'(err_count), 0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
